sipo: RTL and testbench
=======================

SIPO -- requirements
Module: sipo

Interface
REQ-001 Parameter WIDTH, default 4: number of bits in the shift register and in the parallel output; legal range 2..32.
REQ-002 Parameter MSB_FIRST, default 1: 1 = the newest bit enters at bit 0 and older bits move toward the MSB; 0 = the newest bit enters at bit WIDTH-1 and older bits move toward the LSB.
REQ-003 clk  input  1  the only clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset; sampled on the rising edge of clk.
REQ-005 datain  input  1  serial data bit, sampled on every rising edge of clk when reset is low.
REQ-006 dataout  output  WIDTH  parallel contents of the shift register, registered, updated every cycle.
REQ-007 frame_valid  output  1  registered one-cycle pulse marking that dataout holds a complete WIDTH-bit frame.
REQ-008 bit_count  output  clog2(WIDTH)+1  number of bits captured in the current frame, 0..WIDTH-1.

Function
REQ-009 No enable input exists: every rising edge of clk with reset low shifts in exactly one bit.
REQ-010 With MSB_FIRST=1, the next dataout SHALL be {dataout[WIDTH-2:0], datain}.
REQ-011 With MSB_FIRST=0, the next dataout SHALL be {datain, dataout[WIDTH-1:1]}.
REQ-012 Latency: a bit applied before rising edge N appears in dataout after edge N (one cycle), at the entry position.
REQ-013 A bit reaches the far end of dataout WIDTH-1 edges after entry; on the next edge it is discarded.
REQ-014 bit_count increments by 1 on every shift edge and wraps from WIDTH-1 to 0.
REQ-015 frame_valid is high for exactly the cycle after the edge on which bit_count wraps to 0, i.e. after every WIDTH-th bit since reset; it is low otherwise.
REQ-016 While frame_valid is high, dataout holds the last WIDTH bits shifted in, i.e. one complete frame.
REQ-017 Framing continues back-to-back with no gap cycles; frame_valid pulses every WIDTH cycles indefinitely.
REQ-018 The outputs are driven only by flops; there is no combinational path from datain to any output.
REQ-019 An X on datain only affects the register bit it enters; bit_count and frame_valid are never X after reset.

Reset
REQ-020 When reset is high at a rising edge, dataout SHALL become all zeros, bit_count SHALL become 0 and frame_valid SHALL become 0; datain is ignored on that edge.
REQ-021 Reset has priority over shifting.
REQ-022 A reset asserted mid-frame discards the partial frame; framing restarts from bit 0 on the first edge with reset low.
REQ-023 Holding reset for multiple cycles keeps all outputs at their reset values.
REQ-024 No asynchronous reset path exists; outputs are undefined before the first reset edge.

Verification (WIDTH=4, MSB_FIRST=1; clock period 10 ns; stimulus changes on the falling edge)
REQ-025 Reset for 1 cycle -> dataout=0000, bit_count=0, frame_valid=0 after the edge.
REQ-026 After reset, datain=0, 1, 0, 1, 0 on consecutive edges -> dataout=0000, 0001, 0010, 0101, 1010; frame_valid=1 only in the cycle showing 0101.
REQ-027 After REQ-026, datain held at 0 -> dataout=0100, 1000, 0000, then stays at 0000; frame_valid pulses every 4th cycle.
REQ-028 MSB_FIRST=0 with datain=1, 0, 0, 0 from reset -> dataout=1000, 0100, 0010, 0001; frame_valid=1 in the cycle showing 0001.
REQ-029 Reset asserted after 2 bits (dataout=0011) -> next cycle dataout=0000 and bit_count=0; the next frame_valid occurs 4 shifts after reset is released.
REQ-030 Reset held high for 3 cycles while datain toggles -> outputs stay 0000/0/0 throughout.

Source files
------------

// File: rtl/sipo.sv
// Serial-in parallel-out shift register with frame counter.
// Emits a one-cycle frame_valid pulse each time WIDTH new bits have been captured.
module sipo #(
  parameter int unsigned WIDTH     = 4,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    datain,
  output logic [WIDTH-1:0]        dataout,
  output logic                    frame_valid,
  output logic [$clog2(WIDTH):0]  bit_count
);

  localparam int unsigned CW   = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] shift_c;
  logic [CW-1:0]    count_c;
  logic             wrap_c;

  // Entry side of the register is fixed by MSB_FIRST.
  generate
    if (MSB_FIRST) begin : g_msb_first
      assign shift_c = {dataout[WIDTH-2:0], datain};
    end else begin : g_lsb_first
      assign shift_c = {datain, dataout[WIDTH-1:1]};
    end
  endgenerate

  // Frame position counter wraps after the WIDTH-th bit.
  always_comb begin
    wrap_c  = (bit_count == LAST);
    count_c = bit_count + CW'(1);
    if (wrap_c) begin
      count_c = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dataout     <= '0;
      bit_count   <= '0;
      frame_valid <= 1'b0;
    end else begin
      dataout     <= shift_c;
      bit_count   <= count_c;
      frame_valid <= wrap_c;
    end
  end

endmodule

// File: tb/tb_sipo.sv
// Self-checking bench for sipo: directed literal sequences plus randomized
// stimulus compared every cycle against a bit-history model.
module tb_sipo;

  localparam int unsigned W  = 4;
  localparam int unsigned CW = $clog2(W) + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          datain;
  logic [W-1:0]  dout_m, dout_l;
  logic          fv_m, fv_l;
  logic [CW-1:0] bc_m, bc_l;

  int checks = 0;
  int errors = 0;

  // Model state: the last W bits received since reset, and total bits since reset.
  bit hist[$];
  int n      = 0;
  bit mvalid = 1'b0;

  always #5 clk = ~clk;

  sipo #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .reset(reset), .datain(datain),
    .dataout(dout_m), .frame_valid(fv_m), .bit_count(bc_m)
  );

  sipo #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .reset(reset), .datain(datain),
    .dataout(dout_l), .frame_valid(fv_l), .bit_count(bc_l)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Newest bit sits at the entry end; older bits are further away from it.
  function automatic logic [W-1:0] model_data(input bit msb);
    logic [W-1:0] r;
    int           k;
    r = '0;
    for (int i = 0; i < int'(W); i++) begin
      k = hist.size() - 1 - i;
      if (k >= 0) begin
        if (msb) r[i] = hist[k];
        else     r[int'(W) - 1 - i] = hist[k];
      end
    end
    return r;
  endfunction

  always @(posedge clk) begin
    if (reset === 1'b1) begin
      hist.delete();
      n      = 0;
      mvalid = 1'b1;
    end else if (mvalid) begin
      hist.push_back(datain);
      if (hist.size() > int'(W)) void'(hist.pop_front());
      n++;
    end
  end

  always @(negedge clk) begin
    if (mvalid) begin
      chk("msb_dataout", 32'(dout_m), 32'(model_data(1'b1)));
      chk("lsb_dataout", 32'(dout_l), 32'(model_data(1'b0)));
      chk("msb_count",   32'(bc_m),   32'(n % int'(W)));
      chk("lsb_count",   32'(bc_l),   32'(n % int'(W)));
      chk("msb_valid",   32'(fv_m),   32'(n > 0 && n % int'(W) == 0));
      chk("lsb_valid",   32'(fv_l),   32'(n > 0 && n % int'(W) == 0));
    end
  end

  task automatic step(input logic r, input logic d);
    @(negedge clk);
    reset  = r;
    datain = d;
    @(posedge clk);
    #1;
  endtask

  logic [3:0] e26_d [5] = '{4'h0, 4'h1, 4'h2, 4'h5, 4'hA};
  logic       e26_v [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  logic [3:0] e27_d [8] = '{4'h4, 4'h8, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
  logic       e27_v [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  logic [3:0] e28_l [4] = '{4'h8, 4'h4, 4'h2, 4'h1};
  logic [3:0] e28_m [4] = '{4'h1, 4'h2, 4'h4, 4'h8};
  logic       in26  [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  logic       in28  [4] = '{1'b1, 1'b0, 1'b0, 1'b0};

  initial begin
    reset  = 1'b1;
    datain = 1'b0;

    // Single reset cycle.
    step(1'b1, 1'b1);
    chk("rst_dataout", 32'(dout_m), 32'h0);
    chk("rst_count",   32'(bc_m),   32'h0);
    chk("rst_valid",   32'(fv_m),   32'h0);

    // 0,1,0,1,0 after reset.
    for (int i = 0; i < 5; i++) begin
      step(1'b0, in26[i]);
      chk("seq26_dataout", 32'(dout_m), 32'(e26_d[i]));
      chk("seq26_valid",   32'(fv_m),   32'(e26_v[i]));
    end

    // Hold zero; data drains and frames keep pulsing.
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b0);
      chk("seq27_dataout", 32'(dout_m), 32'(e27_d[i]));
      chk("seq27_valid",   32'(fv_m),   32'(e27_v[i]));
    end

    // 1,0,0,0 from reset on both orderings.
    step(1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, in28[i]);
      chk("seq28_lsb_dataout", 32'(dout_l), 32'(e28_l[i]));
      chk("seq28_msb_dataout", 32'(dout_m), 32'(e28_m[i]));
      chk("seq28_lsb_valid",   32'(fv_l),   32'(i == 3));
    end

    // Mid-frame reset discards the partial frame.
    step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    chk("seq29_partial", 32'(dout_m), 32'h3);
    step(1'b1, 1'b1);
    chk("seq29_rst_dataout", 32'(dout_m), 32'h0);
    chk("seq29_rst_count",   32'(bc_m),   32'h0);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1);
      chk("seq29_valid", 32'(fv_m), 32'(i == 3));
    end

    // Reset held three cycles with toggling data.
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'(i % 2));
      chk("seq30_dataout", 32'(dout_m), 32'h0);
      chk("seq30_count",   32'(bc_m),   32'h0);
      chk("seq30_valid",   32'(fv_m),   32'h0);
    end

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 800; i++) begin
      step(1'($urandom_range(0, 14) == 0), 1'($urandom_range(0, 1)));
    end

    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
